// File: rtl/muldiv_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_pkg
// Shared types and constants for the RV32M multiply/divide sequencer.
//   XLEN_DEF  default operand/result width (also the iteration count)
//   op_e      funct3 encoding of the eight M-extension operations
//   state_e   sequencer states
// ---------------------------------------------------------------------------
package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Divide and remainder ops share funct3[2] = 1.
    function automatic logic is_div_op(input op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// muldiv_seq_ctrl_if
// EX-stage request/response bundle between the pipeline and the M unit.
//   start   M-op valid in EX          funct3  operation select
//   rs1     operand A                 rs2     operand B
//   flush   EX-stage kill             stall   hold IF/ID/EX
//   done    one-cycle result valid    result  registered result
// master: pipeline side, slave: sequencer side.
// ---------------------------------------------------------------------------
interface muldiv_seq_ctrl_if
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, rs1, rs2, flush,
        input  stall, done, result
    );

    modport slave (
        input  start, funct3, rs1, rs2, flush,
        output stall, done, result
    );
endinterface

// File: rtl/muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
// One radix-2 iteration of the shared multiply/divide datapath (pure comb).
//   is_div_i  1: restoring-divide step, 0: shift-add multiply step
//   hi_i      product high word / partial remainder
//   lo_i      multiplier (shifting out) / dividend-quotient (shifting)
//   opnd_i    multiplicand / divisor
//   hi_o      next hi word
//   lo_o      next lo word
// ---------------------------------------------------------------------------
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opnd_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            q_bit;

    always_comb begin
        // Multiply: add multiplicand on the multiplier's LSB, keep the carry
        // so the 2*XLEN shift below never loses a bit.
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
        // Divide: bring the next dividend bit into the partial remainder.
        shifted = {hi_i, lo_i[XLEN-1]};
        q_bit   = (shifted >= {1'b0, opnd_i});
        // When q_bit is set the true difference is below the divisor, so the
        // low XLEN bits of the subtraction are exact.
        diff    = shifted[XLEN-1:0] - opnd_i;

        if (is_div_i) begin
            hi_o = q_bit ? diff : shifted[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], q_bit};
        end else begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_seq_ctrl
// Multi-cycle sequencer for RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// Operands are made non-negative on entry, XLEN radix-2 steps run in CALC,
// and the sign is restored while the result is registered for DONE.
// Divide-by-zero and signed overflow bypass CALC entirely.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   muldiv_seq_ctrl_if slave (start/funct3/rs1/rs2/flush in,
//         stall/done/result out)
// ---------------------------------------------------------------------------
module muldiv_seq_ctrl
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    muldiv_seq_ctrl_if.slave bus
);
    localparam int              CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q, state_d;
    op_e               op_q;
    logic              neg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   hi_q, lo_q, opnd_q, result_q;

    // ---- request decode (only meaningful in IDLE) ----
    op_e             op_in;
    logic            sign_a, sign_b, neg_in;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_by_zero, div_ovf, special, accept;
    logic [XLEN-1:0] special_res;

    assign op_in = op_e'(bus.funct3);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        sign_a      = 1'b0;
        sign_b      = 1'b0;
        special_res = '0;

        if (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) sign_a = bus.rs1[XLEN-1];
        if (op_in inside {OP_MULH, OP_DIV, OP_REM})            sign_b = bus.rs2[XLEN-1];

        abs_a  = sign_a ? -bus.rs1 : bus.rs1;
        abs_b  = sign_b ? -bus.rs2 : bus.rs2;
        // Remainder takes the dividend's sign; everything else the XOR.
        neg_in = (op_in == OP_REM) ? sign_a : (sign_a ^ sign_b);

        div_by_zero = is_div_op(op_in) && (bus.rs2 == '0);
        div_ovf     = (op_in inside {OP_DIV, OP_REM}) && (bus.rs1 == INT_MIN) && (bus.rs2 == '1);
        special     = div_by_zero || div_ovf;

        // funct3[1] separates REM/REMU from DIV/DIVU.
        if (div_by_zero) special_res = bus.funct3[1] ? bus.rs1 : '1;
        else             special_res = bus.funct3[1] ? '0 : INT_MIN;
    end

    assign accept = (state_q == ST_IDLE) && bus.start && !bus.flush;

    // ---- datapath step and sign fix-up ----
    logic [XLEN-1:0]   step_hi, step_lo;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fin_res;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i (is_div_op(op_q)),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .opnd_i   (opnd_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    // Fix-up works on the final step's outputs so the result can be
    // registered on the same edge that leaves CALC.
    always_comb begin
        prod_fix = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        case (op_q)
            OP_MUL:                       fin_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fin_res = neg_q ? -step_lo : step_lo;
            default:                      fin_res = neg_q ? -step_hi : step_hi;
        endcase
    end

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (bus.flush)          state_d = ST_IDLE;
                else if (cnt_q == '0)   state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        bus.stall  = accept || (state_q == ST_CALC);
        bus.done   = (state_q == ST_DONE);
        bus.result = result_q;
    end

    // ---- datapath registers ----
    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset as well, so a reset
        // mid-operation leaves no stale operands or result visible.
        if (rst) begin
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    op_q  <= op_in;
                    neg_q <= neg_in;
                    cnt_q <= CNT_W'(XLEN - 1);
                    hi_q  <= '0;
                    // Divide shifts the dividend through lo; multiply shifts
                    // the multiplier through lo and adds the multiplicand.
                    if (is_div_op(op_in)) begin
                        lo_q   <= abs_a;
                        opnd_q <= abs_b;
                    end else begin
                        lo_q   <= abs_b;
                        opnd_q <= abs_a;
                    end
                    if (special) result_q <= special_res;
                end
                ST_CALC: if (!bus.flush) begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) result_q <= fin_res;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_muldiv_seq_ctrl
// Self-checking bench for muldiv_seq_ctrl: directed vector table, hand-written
// flush/reset/back-to-back sequences, and random ops against an arithmetic
// reference model.
// ---------------------------------------------------------------------------
module tb_muldiv_seq_ctrl;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic [31:0] last_exp = '0;

    localparam logic [31:0] MIN32 = 32'h8000_0000;

    muldiv_seq_ctrl_if bus ();

    muldiv_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: RISC-V M semantics in plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (op_e'(f))
            OP_MUL:    begin p = ua * ub;           return p[31:0];  end
            OP_MULH:   begin p = sa * sb;           return p[63:32]; end
            OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            OP_MULHU:  begin p = ua * ub;           return p[63:32]; end
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return MIN32;
                p = sa / sb; return p[31:0];
            end
            OP_DIVU: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Cycles from the start cycle to the done cycle.
    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'b100 || f == 3'b110) && a == MIN32 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return MIN32;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Caller is just after a rising edge; start is raised in this cycle.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input int exp_lat, input string name,
                          output int done_cyc);
        int n, stall_cnt, overlap, lat;
        logic [31:0] res;
        n = 0; stall_cnt = 0; overlap = 0; lat = -1; res = '0; done_cyc = -1;
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.rs1    = a;
        bus.rs2    = b;
        while (lat < 0 && n <= 60) begin
            @(negedge clk);
            if (bus.stall) stall_cnt++;
            if (bus.stall && bus.done) overlap++;
            if (bus.done) begin
                lat      = n;
                res      = bus.result;
                done_cyc = cyc;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            n++;
        end
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, {32'b0, res}, {32'b0, exp_r});
        check({name, " stall cycles"}, 64'(stall_cnt), 64'(exp_lat));
        check({name, " done&stall"}, 64'(overlap), 64'd0);
        last_exp = exp_r;
    endtask

    // Watch an idle stretch: no done, no stall, result held.
    task automatic watch_idle(input int ncyc, input logic [31:0] exp_res, input string name);
        int dn, st;
        dn = 0; st = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (bus.done)  dn++;
            if (bus.stall) st++;
        end
        check({name, " done pulses"}, 64'(dn), 64'd0);
        check({name, " stall cycles"}, 64'(st), 64'd0);
        check({name, " result held"}, {32'b0, bus.result}, {32'b0, exp_res});
        @(posedge clk); #1;
    endtask

    typedef struct packed {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [5:0]  lat;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    initial begin
        int d1, d2, dc;
        logic [2:0]  f;
        logic [31:0] a, b;

        vecs[0]  = '{OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 6'd33};
        vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 6'd33};
        vecs[2]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd33};
        vecs[3]  = '{OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 6'd33};
        vecs[4]  = '{OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 6'd33};
        vecs[5]  = '{OP_DIVU,   32'd100,       32'd7,         32'd14,        6'd33};
        vecs[6]  = '{OP_REMU,   32'd100,       32'd7,         32'd2,         6'd33};
        vecs[7]  = '{OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 6'd1};
        vecs[8]  = '{OP_REM,    32'd7,         32'd0,         32'd7,         6'd1};
        vecs[9]  = '{OP_DIV,    MIN32,         32'hFFFF_FFFF, MIN32,         6'd1};
        vecs[10] = '{OP_REM,    MIN32,         32'hFFFF_FFFF, 32'd0,         6'd1};
        vecs[11] = '{OP_MULH,   MIN32,         MIN32,         32'h4000_0000, 6'd33};
        vecs[12] = '{OP_MUL,    32'h1234_5678, 32'd0,         32'd0,         6'd33};
        vecs[13] = '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         6'd33};
        vecs[14] = '{OP_DIV,    MIN32,         32'd1,         MIN32,         6'd33};
        vecs[15] = '{OP_REMU,   32'd9,         32'd0,         32'd9,         6'd1};

        rst = 1'b1;
        bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0; bus.rs1 = '0; bus.rs2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset stall",  {63'b0, bus.stall}, 64'd0);
        check("reset done",   {63'b0, bus.done},  64'd0);
        check("reset result", {32'b0, bus.result}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors.
        for (int i = 0; i < NVEC; i++)
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, int'(vecs[i].lat),
                   $sformatf("vec%0d", i), dc);

        // Flush in the 10th CALC cycle: no done, result keeps previous value.
        bus.start = 1'b1; bus.funct3 = OP_DIVU; bus.rs1 = 32'd1000; bus.rs2 = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush calc stall", {63'b0, bus.stall}, 64'd1);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        watch_idle(40, last_exp, "flush");
        run_op(OP_MUL, 32'd3, 32'd4, 32'd12, 33, "mul after flush", dc);

        // Reset mid-CALC clears everything and produces no done.
        bus.start = 1'b1; bus.funct3 = OP_DIVU; bus.rs1 = 32'hFFFF_FFFF; bus.rs2 = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        watch_idle(40, 32'd0, "reset mid-calc");

        // Flush beats start in IDLE.
        bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = OP_MUL; bus.rs1 = 32'd5; bus.rs2 = 32'd6;
        @(negedge clk);
        check("flush+start stall", {63'b0, bus.stall}, 64'd0);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        watch_idle(40, 32'd0, "flush+start");

        // Back-to-back DIVU: second start in the cycle after DONE.
        run_op(OP_DIVU, 32'd1000, 32'd7, 32'd142, 33, "b2b first", d1);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33, "b2b second", d2);
        check("b2b done spacing", 64'(d2 - d1), 64'd34);

        // Random ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = rand_opnd();
            b = rand_opnd();
            run_op(f, a, b, ref_result(f, a, b), ref_lat(f, a, b), $sformatf("rand%0d", i), dc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
